// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority encoder.
//   N_IN      : default number of request lines
//   IDX_W     : width of an encoded index
//   prio_idx  : index of the highest set bit (0 when empty)
//   popcount_gt1 : more than one bit set
package irq_pkg;
  localparam int N_IN  = 8;
  localparam int IDX_W = $clog2(N_IN);

  function automatic logic [IDX_W-1:0] prio_idx(input logic [N_IN-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    // Ascending scan, so the last hit (highest index) wins.
    for (int i = 0; i < N_IN; i++)
      if (vec[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  function automatic logic popcount_gt1(input logic [N_IN-1:0] vec);
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    return |(vec & (vec - 1'b1));
  endfunction
endpackage

// File: rtl/irq_priority_encoder_if.sv
// Delivery handshake between the encoder and the event dispatcher.
//   code_out   : encoded index (master -> slave)
//   code_valid : code_out holds an undelivered index
//   multi_hit  : several eligible requests existed when code_out was loaded
//   code_ready : dispatcher accepts code_out (slave -> master)
interface irq_priority_encoder_if #(
  parameter int IDX_W = irq_pkg::IDX_W
);
  logic [IDX_W-1:0] code_out;
  logic             code_valid;
  logic             multi_hit;
  logic             code_ready;

  modport master (output code_out, code_valid, multi_hit, input  code_ready);
  modport slave  (input  code_out, code_valid, multi_hit, output code_ready);
endinterface

// File: rtl/prio_enc_core.sv
// Combinational highest-index-wins priority encoder.
//   vec_i   : eligible request vector
//   idx_o   : index of the highest set bit (0 when vec_i is empty)
//   any_o   : vec_i non-zero
//   multi_o : more than one bit of vec_i set
module prio_enc_core
  import irq_pkg::*;
#(
  parameter int N  = irq_pkg::N_IN,
  parameter int IW = $clog2(N)
)(
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic          multi_o
);
  assign any_o = |vec_i;

  generate
    if (N == N_IN) begin : g_pkg
      assign idx_o   = prio_idx(vec_i);
      assign multi_o = popcount_gt1(vec_i);
    end else begin : g_loop
      always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++)
          if (vec_i[i]) idx_o = IW'(i);
      end
      assign multi_o = |(vec_i & (vec_i - 1'b1));
    end
  endgenerate
endmodule

// File: rtl/irq_priority_encoder.sv
// Latches peripheral request lines into a pending register and hands the
// highest-priority eligible index to the dispatcher over valid/ready.
//   clk, rst_n : clock, async active-low reset
//   req_in     : request lines (edge or level captured, see EDGE_MODE)
//   mask       : 1 = line not eligible for selection (still latches)
//   pending    : current pending register
//   overflow   : sticky, an event hit an already-pending bit
//   bus        : code_out / code_valid / multi_hit / code_ready handshake
module irq_priority_encoder #(
  parameter int N_IN      = irq_pkg::N_IN,
  parameter bit EDGE_MODE = 1'b1
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] req_in,
  input  logic [N_IN-1:0] mask,
  output logic [N_IN-1:0] pending,
  output logic            overflow,
  irq_priority_encoder_if.master bus
);
  localparam int IDX_W = $clog2(N_IN);

  logic [N_IN-1:0]  req_q, pending_q, pending_d;
  logic [IDX_W-1:0] code_q, code_d;
  logic             valid_q, valid_d, multi_q, multi_d, ovf_q, ovf_d;

  logic [N_IN-1:0]  evt, elig, clr;
  logic [IDX_W-1:0] win_idx;
  logic             win_any, win_multi, slot_free, load;

  // req_q resets to 0, so a line held through reset release gives one edge.
  assign evt  = EDGE_MODE ? (req_in & ~req_q) : req_in;
  assign elig = pending_q & ~mask;

  prio_enc_core #(.N(N_IN), .IW(IDX_W)) u_core (
    .vec_i   (elig),
    .idx_o   (win_idx),
    .any_o   (win_any),
    .multi_o (win_multi)
  );

  assign slot_free = !valid_q || bus.code_ready;
  assign load      = slot_free && win_any;
  assign clr       = load ? (N_IN'(1) << win_idx) : '0;

  always_comb begin
    // A new event on the bit being cleared this edge survives (OR after clear).
    pending_d = (pending_q & ~clr) | evt;
    ovf_d     = ovf_q | (|(evt & pending_q & ~clr));
    valid_d   = slot_free ? win_any : valid_q;
    code_d    = load ? win_idx   : code_q;
    multi_d   = load ? win_multi : multi_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      req_q     <= req_in;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending        = pending_q;
  assign overflow       = ovf_q;
  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.multi_hit  = multi_q;
endmodule
